// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, latency default and controller state type for the data memory
//
// Shared by the data memory and the data cache so that both sides agree on
// block geometry. No ports.
package mem_pkg;

    localparam int BLOCK_ADDR_W        = 6;
    localparam int BLOCK_DATA_W        = 32;
    localparam int DEFAULT_MEM_LATENCY = 5;

    // Holds LATENCY-2 for the largest legal latency (16 -> 14).
    localparam int MEM_CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

endpackage

// File: rtl/data_memory_block_if.sv
// rtl/data_memory_block_if.sv - cache-to-data-memory block request bus
//
// master (cache):  drives mem_read, mem_write, mem_address, mem_writedata
//                  receives mem_readdata, mem_busywait, protocol_error
// slave (memory):  the mirror image
interface data_memory_block_if #(
    parameter int ADDR_W  = mem_pkg::BLOCK_ADDR_W,
    parameter int BLOCK_W = mem_pkg::BLOCK_DATA_W
);
    logic               mem_read;
    logic               mem_write;
    logic [ADDR_W-1:0]  mem_address;
    logic [BLOCK_W-1:0] mem_writedata;
    logic [BLOCK_W-1:0] mem_readdata;
    logic               mem_busywait;
    logic               protocol_error;

    modport master (
        output mem_read, mem_write, mem_address, mem_writedata,
        input  mem_readdata, mem_busywait, protocol_error
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_writedata,
        output mem_readdata, mem_busywait, protocol_error
    );
endinterface

// File: rtl/block_ram_sp.sv
// rtl/block_ram_sp.sv - single-port synchronous block RAM with registered read, no reset
//
// clock : rising-edge clock
// we    : write wdata to addr at the edge
// re    : load rdata from addr at the edge; rdata holds otherwise
// addr  : block address
// wdata : block to write
// rdata : registered read result
module block_ram_sp #(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/data_memory_block.sv
// rtl/data_memory_block.sv - fixed-latency block data memory behind the data cache
//
// clock : rising-edge clock
// reset : synchronous, active-high; clears controller state, not the array
// bus   : slave side of data_memory_block_if
//         mem_read/mem_write/mem_address/mem_writedata in,
//         mem_readdata (registered), mem_busywait (combinational),
//         protocol_error (sticky: read and write requested together)
module data_memory_block
    import mem_pkg::*;
#(
    parameter int ADDR_W  = BLOCK_ADDR_W,
    parameter int BLOCK_W = BLOCK_DATA_W,
    parameter int LATENCY = DEFAULT_MEM_LATENCY
) (
    input  logic               clock,
    input  logic               reset,
    data_memory_block_if.slave bus
);
    generate
        if (LATENCY < 2 || LATENCY > 16) begin : g_bad_latency
            $error("data_memory_block: LATENCY must be within 2..16");
        end
    endgenerate

    mem_state_e           state;
    mem_state_e           state_next;
    logic [MEM_CNT_W-1:0] count;
    logic                 lat_write;
    logic [ADDR_W-1:0]    lat_addr;
    logic [BLOCK_W-1:0]   lat_wdata;
    logic                 rd_valid;
    logic                 perr;
    logic [BLOCK_W-1:0]   ram_q;

    logic req_one;
    logic req_both;
    logic accept;
    logic access;
    logic busy;

    always_comb begin
        req_one    = bus.mem_read ^ bus.mem_write;
        req_both   = bus.mem_read & bus.mem_write;
        state_next = state;
        accept     = 1'b0;
        access     = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (req_one) begin
                    accept     = 1'b1;
                    busy       = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (count == '0) begin
                    // A reset landing on the commit edge must drop the write.
                    access     = !reset;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rd_valid  <= 1'b0;
            perr      <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                lat_write <= bus.mem_write;
                lat_addr  <= bus.mem_address;
                lat_wdata <= bus.mem_writedata;
                count     <= MEM_CNT_W'(LATENCY - 2);
            end else if (state == BUSY && count != '0) begin
                count <= count - 1'b1;
            end
            if (state == IDLE && req_both) begin
                perr <= 1'b1;
            end
            if (access && !lat_write) begin
                rd_valid <= 1'b1;
            end
        end
    end

    block_ram_sp #(
        .AW (ADDR_W),
        .DW (BLOCK_W)
    ) u_ram (
        .clock (clock),
        .we    (access & lat_write),
        .re    (access & ~lat_write),
        .addr  (lat_addr),
        .wdata (lat_wdata),
        .rdata (ram_q)
    );

    // The RAM output register has no reset, so readdata reads as zero
    // until the first read after reset has refreshed it.
    assign bus.mem_readdata   = rd_valid ? ram_q : '0;
    assign bus.mem_busywait   = busy;
    assign bus.protocol_error = perr;
endmodule

// File: tb/tb_data_memory_block.sv
// tb/tb_data_memory_block.sv - self-checking bench for data_memory_block (LATENCY 5 and 2)
module tb_data_memory_block;
    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    data_memory_block_if #(.ADDR_W(6), .BLOCK_W(32)) bus5 ();
    data_memory_block_if #(.ADDR_W(6), .BLOCK_W(32)) bus2 ();

    data_memory_block #(.ADDR_W(6), .BLOCK_W(32), .LATENCY(5)) dut5 (
        .clock (clock),
        .reset (reset),
        .bus   (bus5)
    );

    data_memory_block #(.ADDR_W(6), .BLOCK_W(32), .LATENCY(2)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2)
    );

    int vectors = 0;
    int errs    = 0;

    // Reference: array contents and the last value each instance returned.
    logic [31:0] model5 [64];
    logic [31:0] model2 [64];
    logic [31:0] rd5 = '0;
    logic [31:0] rd2 = '0;
    logic [5:0]  written5 [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit l2, input bit rd, input bit wr, input logic [5:0] a, input logic [31:0] d);
        if (l2) begin
            bus2.mem_read = rd; bus2.mem_write = wr; bus2.mem_address = a; bus2.mem_writedata = d;
        end else begin
            bus5.mem_read = rd; bus5.mem_write = wr; bus5.mem_address = a; bus5.mem_writedata = d;
        end
    endtask

    // One complete request: busywait must stay high exactly `lat` cycles,
    // and in the following (DONE) cycle the read result must be visible.
    task automatic access(input bit l2, input bit wr, input logic [5:0] a, input logic [31:0] d, input string tag);
        int hi;
        int lat;
        logic bw;
        logic [31:0] q;
        lat = l2 ? 2 : 5;
        @(negedge clock);
        drive(l2, !wr, wr, a, d);
        hi = 0;
        #1 bw = l2 ? bus2.mem_busywait : bus5.mem_busywait;
        while (bw && hi < 40) begin
            hi++;
            @(negedge clock);
            #1 bw = l2 ? bus2.mem_busywait : bus5.mem_busywait;
        end
        check({tag, "_busy_cycles"}, 32'(hi), 32'(lat));
        if (wr) begin
            if (l2) model2[a] = d; else begin model5[a] = d; written5.push_back(a); end
        end else begin
            if (l2) rd2 = model2[a]; else rd5 = model5[a];
        end
        q = l2 ? bus2.mem_readdata : bus5.mem_readdata;
        check({tag, "_readdata"}, q, l2 ? rd2 : rd5);
        drive(l2, 1'b0, 1'b0, a, d);
    endtask

    initial begin
        int falls;
        logic prev_bw;
        logic bw;
        logic [5:0]  a;
        logic [31:0] d;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset_readdata", bus5.mem_readdata, 32'h0);
        check("reset_busywait", 32'(bus5.mem_busywait), 32'h0);
        check("reset_perr", 32'(bus5.protocol_error), 32'h0);

        access(1'b0, 1'b1, 6'h2A, 32'hDEADBEEF, "wr_2a");
        access(1'b0, 1'b0, 6'h2A, 32'h0, "rd_2a");
        check("perr_after_basic", 32'(bus5.protocol_error), 32'h0);

        access(1'b0, 1'b1, 6'h00, 32'h11223344, "wr_00");
        access(1'b0, 1'b1, 6'h3F, 32'h55667788, "wr_3f");
        access(1'b0, 1'b0, 6'h00, 32'h0, "rd_00");
        access(1'b0, 1'b0, 6'h3F, 32'h0, "rd_3f");
        repeat (3) @(negedge clock);
        #1 check("hold_readdata_idle", bus5.mem_readdata, 32'h55667788);

        // Read held high through DONE: busywait pattern repeats with period
        // LATENCY+1, so exactly one access completes per 6 cycles.
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b0, 6'h2A, '0);
        falls = 0;
        prev_bw = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1 bw = bus5.mem_busywait;
            check($sformatf("held_bw_c%0d", c), 32'(bw), 32'((c % 6) != 5));
            if (prev_bw && !bw) falls++;
            if (c == 5) check("held_rd_done", bus5.mem_readdata, model5[6'h2A]);
            prev_bw = bw;
            @(negedge clock);
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        rd5 = model5[6'h2A];
        check("held_access_count", 32'(falls), 32'd2);

        // Randomised traffic against the reference array.
        for (int i = 0; i < 24; i++) begin
            if (written5.size() == 0 || $urandom_range(0, 1) == 0) begin
                a = 6'($urandom_range(0, 63));
                d = $urandom;
                access(1'b0, 1'b1, a, d, $sformatf("rnd_wr%0d", i));
            end else begin
                a = written5[$urandom_range(0, written5.size() - 1)];
                access(1'b0, 1'b0, a, 32'h0, $sformatf("rnd_rd%0d", i));
            end
        end

        // Both requests together: refused, flag sticks.
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b1, 6'h3F, 32'h12345678);
        for (int c = 0; c < 3; c++) begin
            #1 check("both_busywait", 32'(bus5.mem_busywait), 32'h0);
            @(negedge clock);
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        #1 check("both_perr", 32'(bus5.protocol_error), 32'h1);
        check("both_no_access", bus5.mem_readdata, rd5);
        access(1'b0, 1'b0, 6'h00, 32'h0, "rd_after_both");
        check("perr_sticky", 32'(bus5.protocol_error), 32'h1);

        // Reset while a write is in BUSY cycle 2: the write must be lost.
        access(1'b0, 1'b1, 6'h10, 32'hCAFEF00D, "wr_10");
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b1, 6'h10, 32'h0BADF00D);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clock);
        reset = 1'b0;
        rd5 = '0;
        rd2 = '0;
        #1;
        check("rst_mid_busywait", 32'(bus5.mem_busywait), 32'h0);
        check("rst_mid_readdata", bus5.mem_readdata, 32'h0);
        check("rst_mid_perr", 32'(bus5.protocol_error), 32'h0);
        access(1'b0, 1'b0, 6'h10, 32'h0, "rd_10_after_rst");
        check("rd_10_value", bus5.mem_readdata, 32'hCAFEF00D);

        // Minimum-latency instance.
        for (int i = 0; i < 6; i++) begin
            a = 6'($urandom_range(0, 63));
            d = $urandom;
            access(1'b1, 1'b1, a, d, $sformatf("l2_wr%0d", i));
            access(1'b1, 1'b0, a, 32'h0, $sformatf("l2_rd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/data_memory_block.md
Name: data_memory_block

Overview:
- Block-organised data memory directly downstream of the CPU data cache; it serves the cache's miss refills and dirty write-backs.
- 64 blocks x 32 bits, addressed by 6-bit block address ({tag, index}).
- Fixed multi-cycle access latency, signalled to the cache through a mem_busywait handshake.

Parameters:
ADDR_W, 6, block address width (depth = 2**ADDR_W)
BLOCK_W, 32, block data width
LATENCY, 5, cycles mem_busywait stays high per access (legal range 2..16; elaboration error otherwise)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high
mem_read  input  1  block read request from cache, held until busywait falls
mem_write  input  1  block write request from cache, held until busywait falls
mem_address  input  ADDR_W  block address of request
mem_writedata  input  BLOCK_W  block to write
mem_readdata  output  BLOCK_W  block read result, registered
mem_busywait  output  1  high while a request is pending or in service
protocol_error  output  1  sticky flag, read and write requested together

Behaviour:
- Reset: clock is clock; reset is reset, synchronous, active-high. On reset, state=IDLE, mem_readdata=0, protocol_error=0, counter=0, latched request cleared. Storage array is NOT cleared.
- States: IDLE, BUSY, DONE.
- mem_busywait is combinational: (IDLE and exactly one of mem_read/mem_write high) or BUSY. In DONE it is 0.
- IDLE:
  - Exactly one request high at a rising edge: latch op, mem_address and mem_writedata; load counter with LATENCY-2; go to BUSY.
  - Neither request high: stay in IDLE.
  - Both high: no acceptance, stay in IDLE, busywait 0, set protocol_error (cleared only by reset).
- BUSY:
  - counter != 0: decrement.
  - counter == 0: perform access at that edge using latched values, then go to DONE. A read loads mem_readdata from array[addr]; a write stores array[addr] = writedata.
  - Request inputs are ignored in BUSY. Only latched values are used, so input changes mid-access are harmless.
- DONE: lasts one cycle, busywait 0, unconditional transition to IDLE. Requests still asserted in DONE are ignored. This lets the cache drop or retarget its request without a double acceptance.
- Latency: request first visible in cycle 0.
  - busywait is high in cycles 0..LATENCY-1 and low in cycle LATENCY (DONE).
  - Read data is valid from cycle LATENCY onward.
  - The earliest next acceptance is the edge ending cycle LATENCY+1 (back in IDLE).
- mem_readdata holds its last read value. Writes and idle cycles do not change it.
- A write followed by a read to the same address returns the written block. The write commits before DONE.
- Reset mid-access: an uncommitted write is dropped and array contents are untouched. State returns to IDLE; busywait falls in the cycle after the reset edge unless a new request is present.
- Address wrap: none. The address is exactly ADDR_W bits and all 64 blocks are valid.

Decomposition:
- Shared package mem_pkg:
  - state enum (IDLE, BUSY, DONE)
  - constants BLOCK_ADDR_W=6, BLOCK_DATA_W=32, DEFAULT_MEM_LATENCY=5
  - the cache imports the same widths
- One sub-module, block_ram_sp: single-port synchronous RAM, one write enable, registered read, no reset. The controller FSM and counter stay in data_memory_block.

Test Plan:
- Write 0xDEADBEEF to block 0x2A, then read 0x2A -> busywait high exactly 5 cycles each; readdata=0xDEADBEEF in the DONE cycle; protocol_error=0.
- Write 0x11223344 to 0x00 and 0x55667788 to 0x3F, then read both -> correct blocks returned; readdata holds 0x55667788 after the final read while idle.
- Cache holds mem_read high through DONE and into the next cycle -> exactly one access; the second acceptance occurs only at the edge ending cycle 6. Check via busywait timing and an access counter in the bench.
- mem_read and mem_write both high in IDLE -> no access, busywait 0, protocol_error=1 and stays 1 until reset.
- Write 0xCAFEF00D to 0x10 completes; start write 0x0BADF00D to 0x10; assert reset in BUSY cycle 2 -> IDLE, readdata=0, busywait 0. A subsequent read of 0x10 returns 0xCAFEF00D.
- LATENCY=2 instance: read request -> busywait high cycles 0..1, DONE in cycle 2, readdata valid in cycle 2.
